// File: rtl/fc_capture_pkg.sv
// Shared types for the FC output capture block.
// State encoding and argmax reset constants.
package fc_capture_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int ARGMAX_IDX_RST = 0;

  // Only the sign bit set: the most negative w-bit value.
  function automatic logic [63:0] argmax_val_rst(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/capture_regfile.sv
// M x T capture buffer with one write port
// and one registered read port (out of range reads give 0).
module capture_regfile #(
  parameter int M = 10,
  parameter int T = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [$clog2(M)-1:0] waddr,
  input  logic signed [T-1:0]  wdata,
  input  logic [$clog2(M)-1:0] raddr,
  output logic signed [T-1:0]  rdata
);

  logic signed [T-1:0] mem_q [M];
  logic signed [T-1:0] rdata_q, rdata_d;

  // Storage is never cleared; only written words matter.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read mux with range guard.
  always_comb begin
    rdata_d = '0;
    if (int'(raddr) < M) rdata_d = mem_q[raddr];
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fc_out_capture.sv
// Captures one M-word output vector from an FC layer and holds it.
// Optional argmax tracking: define FC_CAPTURE_ARGMAX_EN.
module fc_out_capture
  import fc_capture_pkg::*;
#(
  parameter int M = 10,
  parameter int T = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic signed [T-1:0]  input_data,
  output logic                 vec_valid,
  input  logic                 vec_ack,
  input  logic [$clog2(M)-1:0] rd_addr,
`ifdef FC_CAPTURE_ARGMAX_EN
  output logic signed [T-1:0]  rd_data,
  output logic [$clog2(M)-1:0] argmax_idx,
  output logic signed [T-1:0]  argmax_val
`else
  output logic signed [T-1:0]  rd_data
`endif
);

  localparam int AW = $clog2(M);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic          xfer;
  logic          last;

  assign xfer = input_valid && (state_q == FILL);
  assign last = (wr_idx_q == AW'(M - 1));

  // Next state and write index.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    unique case (state_q)
      FILL: begin
        if (xfer) begin
          wr_idx_d = last ? '0 : wr_idx_q + AW'(1);
          if (last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (vec_ack) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // State and index registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= FILL;
      wr_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  assign input_ready = (state_q == FILL);
  assign vec_valid   = (state_q == HOLD);

  capture_regfile #(
    .M(M),
    .T(T)
  ) u_regfile (
    .clk  (clk),
    .reset(reset),
    .we   (xfer && reset),
    .waddr(wr_idx_q),
    .wdata(input_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

`ifdef FC_CAPTURE_ARGMAX_EN
  logic [AW-1:0]       amax_idx_q, amax_idx_d;
  logic signed [T-1:0] amax_val_q, amax_val_d;

  // Word 0 always loads; later words replace only if strictly greater.
  always_comb begin
    amax_idx_d = amax_idx_q;
    amax_val_d = amax_val_q;
    if (xfer && (wr_idx_q == '0 || input_data > amax_val_q)) begin
      amax_idx_d = wr_idx_q;
      amax_val_d = input_data;
    end
  end

  // Argmax registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      amax_idx_q <= AW'(ARGMAX_IDX_RST);
      amax_val_q <= T'(argmax_val_rst(T));
    end else begin
      amax_idx_q <= amax_idx_d;
      amax_val_q <= amax_val_d;
    end
  end

  assign argmax_idx = amax_idx_q;
  assign argmax_val = amax_val_q;
`endif

endmodule

// File: tb/tb_fc_out_capture.sv
// Directed bench for fc_out_capture (M=10, T=16).
// Argmax checks are built when FC_CAPTURE_ARGMAX_EN is defined.
module tb_fc_out_capture;

  logic               clk;
  logic               reset;
  logic               input_valid;
  logic               input_ready;
  logic signed [15:0] input_data;
  logic               vec_valid;
  logic               vec_ack;
  logic [3:0]         rd_addr;
  logic signed [15:0] rd_data;
`ifdef FC_CAPTURE_ARGMAX_EN
  logic [3:0]         argmax_idx;
  logic signed [15:0] argmax_val;
`endif

  int n_chk;
  int n_fail;

  logic signed [15:0] exp_a [10];
  logic signed [15:0] exp_b [10];
  logic signed [15:0] exp_c [10];
  logic signed [15:0] exp_d [10];

  fc_out_capture #(
    .M(10),
    .T(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .input_valid(input_valid),
    .input_ready(input_ready),
    .input_data (input_data),
    .vec_valid  (vec_valid),
    .vec_ack    (vec_ack),
    .rd_addr    (rd_addr),
`ifdef FC_CAPTURE_ARGMAX_EN
    .rd_data    (rd_data),
    .argmax_idx (argmax_idx),
    .argmax_val (argmax_val)
`else
    .rd_data    (rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic release_vec;
    vec_ack = 1'b1;
    tick();
    vec_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset       = 1'b0;
    input_valid = 1'b1;
    input_data  = 16'sd5;
    vec_ack     = 1'b1;
    rd_addr     = 4'd0;
    tick();
    tick();
    n_chk++;
    if (vec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vec_valid: got %b expected 0", vec_valid);
    end
    n_chk++;
    if (input_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_input_ready: got %b expected 1", input_ready);
    end
    n_chk++;
    if (rd_data !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %0d expected 0", rd_data);
    end
`ifdef FC_CAPTURE_ARGMAX_EN
    n_chk++;
    if (argmax_idx !== 4'd0 || argmax_val !== 16'sh8000) begin
      n_fail++;
      $display("FAIL reset_argmax: got %0d/%0d expected 0/-32768",
               argmax_idx, argmax_val);
    end
`endif
    reset       = 1'b1;
    input_valid = 1'b0;
    vec_ack     = 1'b0;
    tick();
  endtask

  task automatic test_stream;
    for (int i = 0; i < 10; i++) begin
      input_valid = 1'b1;
      input_data  = exp_a[i];
      tick();
      n_chk++;
      if (vec_valid !== (i == 9) || input_ready !== (i != 9)) begin
        n_fail++;
        $display("FAIL stream_word%0d: got valid=%b ready=%b expected %b/%b",
                 i, vec_valid, input_ready, i == 9, i != 9);
      end
    end
    input_valid = 1'b0;
  endtask

  task automatic test_read;
    for (int a = 0; a < 10; a++) begin
      rd_addr = 4'(a);
      tick();
      n_chk++;
      if (rd_data !== exp_a[a]) begin
        n_fail++;
        $display("FAIL read_addr%0d: got %0d expected %0d", a, rd_data, exp_a[a]);
      end
    end
    rd_addr = 4'd12;
    #1;
    n_chk++;
    if (rd_data !== exp_a[9]) begin
      n_fail++;
      $display("FAIL read_latency: got %0d expected %0d", rd_data, exp_a[9]);
    end
    tick();
    n_chk++;
    if (rd_data !== 16'sd0) begin
      n_fail++;
      $display("FAIL read_oob12: got %0d expected 0", rd_data);
    end
  endtask

  task automatic test_hold_ignore;
    input_valid = 1'b1;
    input_data  = 16'sd99;
    rd_addr     = 4'd0;
    repeat (3) tick();
    n_chk++;
    if (vec_valid !== 1'b1 || input_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ignore_state: got valid=%b ready=%b expected 1/0",
               vec_valid, input_ready);
    end
    input_valid = 1'b0;
    for (int a = 0; a < 10; a++) begin
      rd_addr = 4'(a);
      tick();
      n_chk++;
      if (rd_data !== exp_a[a]) begin
        n_fail++;
        $display("FAIL hold_keep_addr%0d: got %0d expected %0d", a, rd_data, exp_a[a]);
      end
    end
    release_vec();
    n_chk++;
    if (vec_valid !== 1'b0 || input_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_release: got valid=%b ready=%b expected 0/1",
               vec_valid, input_ready);
    end
    rd_addr = 4'd5;
    tick();
    n_chk++;
    if (rd_data !== exp_a[5]) begin
      n_fail++;
      $display("FAIL retain_after_ack: got %0d expected %0d", rd_data, exp_a[5]);
    end
    for (int i = 0; i < 10; i++) begin
      input_valid = 1'b1;
      input_data  = exp_b[i];
      tick();
      n_chk++;
      if (vec_valid !== (i == 9)) begin
        n_fail++;
        $display("FAIL second_vec_word%0d: got valid=%b expected %b",
                 i, vec_valid, i == 9);
      end
    end
    input_valid = 1'b0;
    for (int a = 0; a < 10; a++) begin
      rd_addr = 4'(a);
      tick();
      n_chk++;
      if (rd_data !== exp_b[a]) begin
        n_fail++;
        $display("FAIL second_vec_addr%0d: got %0d expected %0d", a, rd_data, exp_b[a]);
      end
    end
  endtask

  task automatic test_reset_mid;
    release_vec();
    for (int i = 0; i < 4; i++) begin
      input_valid = 1'b1;
      input_data  = 16'sd1111;
      tick();
    end
    reset       = 1'b0;
    input_valid = 1'b1;
    input_data  = 16'sd77;
    vec_ack     = 1'b1;
    tick();
    reset       = 1'b1;
    input_valid = 1'b0;
    vec_ack     = 1'b0;
    n_chk++;
    if (vec_valid !== 1'b0 || input_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_state: got valid=%b ready=%b expected 0/1",
               vec_valid, input_ready);
    end
    for (int i = 0; i < 10; i++) begin
      input_valid = 1'b1;
      input_data  = exp_c[i];
      tick();
      n_chk++;
      if (vec_valid !== (i == 9)) begin
        n_fail++;
        $display("FAIL post_reset_word%0d: got valid=%b expected %b",
                 i, vec_valid, i == 9);
      end
    end
    input_valid = 1'b0;
    for (int a = 0; a < 10; a++) begin
      rd_addr = 4'(a);
      tick();
      n_chk++;
      if (rd_data !== exp_c[a]) begin
        n_fail++;
        $display("FAIL post_reset_addr%0d: got %0d expected %0d", a, rd_data, exp_c[a]);
      end
    end
  endtask

  task automatic test_random_gaps;
    release_vec();
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) begin
        input_valid = 1'b0;
        vec_ack     = 1'($urandom_range(0, 1));
        input_data  = 16'($urandom);
        tick();
        n_chk++;
        if (vec_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_before_word%0d: got valid=%b expected 0", i, vec_valid);
        end
      end
      input_valid = 1'b1;
      vec_ack     = 1'($urandom_range(0, 1));
      input_data  = exp_d[i];
      tick();
      n_chk++;
      if (vec_valid !== (i == 9)) begin
        n_fail++;
        $display("FAIL gap_word%0d: got valid=%b expected %b", i, vec_valid, i == 9);
      end
    end
    input_valid = 1'b0;
    vec_ack     = 1'b0;
    for (int a = 0; a < 10; a++) begin
      rd_addr = 4'(a);
      tick();
      n_chk++;
      if (rd_data !== exp_d[a]) begin
        n_fail++;
        $display("FAIL gap_addr%0d: got %0d expected %0d", a, rd_data, exp_d[a]);
      end
    end
  endtask

`ifdef FC_CAPTURE_ARGMAX_EN
  task automatic test_argmax;
    logic signed [15:0] v1 [10];
    logic signed [15:0] v2 [10];
    v1 = '{16'sd5, -16'sd3, 16'sd9, 16'sd9, 16'sd2,
           16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    v2 = '{-16'sd50, -16'sd7, -16'sd100, -16'sd7, -16'sd9,
           -16'sd20, -16'sd30, -16'sd40, -16'sd60, -16'sd8};
    release_vec();
    for (int i = 0; i < 10; i++) begin
      input_valid = 1'b1;
      input_data  = v1[i];
      tick();
    end
    input_valid = 1'b0;
    tick();
    n_chk++;
    if (argmax_idx !== 4'd2 || argmax_val !== 16'sd9) begin
      n_fail++;
      $display("FAIL argmax_ties: got %0d/%0d expected 2/9", argmax_idx, argmax_val);
    end
    release_vec();
    for (int i = 0; i < 10; i++) begin
      input_valid = 1'b1;
      input_data  = v2[i];
      tick();
    end
    input_valid = 1'b0;
    n_chk++;
    if (argmax_idx !== 4'd1 || argmax_val !== -16'sd7) begin
      n_fail++;
      $display("FAIL argmax_negative: got %0d/%0d expected 1/-7",
               argmax_idx, argmax_val);
    end
  endtask
`endif

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    input_valid = 1'b0;
    input_data  = '0;
    vec_ack     = 1'b0;
    rd_addr     = '0;
    exp_a = '{-16'sd87, 16'sd53, 16'sd120, -16'sd300, 16'sd7,
              16'sd0, 16'sd32767, 16'sh8000, 16'sd1000, -16'sd12};
    exp_b = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5,
              -16'sd6, -16'sd7, -16'sd8, -16'sd9, -16'sd10};
    exp_c = '{16'sd400, -16'sd401, 16'sd402, -16'sd403, 16'sd404,
              -16'sd405, 16'sd406, -16'sd407, 16'sd408, -16'sd409};
    exp_d = '{16'sd11, -16'sd22, 16'sd33, -16'sd44, 16'sd55,
              -16'sd66, 16'sd77, -16'sd88, 16'sd99, -16'sd111};
    test_reset();
    test_stream();
    test_read();
    test_hold_ignore();
    test_reset_mid();
    test_random_gaps();
`ifdef FC_CAPTURE_ARGMAX_EN
    test_argmax();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_out_capture.md
FC_OUT_CAPTURE -- requirements
Module: fc_out_capture

Interface
REQ-001 The module SHALL take parameter M, default 10, meaning output-vector length (words per vector).
REQ-002 The module SHALL take parameter T, default 16, meaning signed word width.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 The module SHALL have port input_valid, input, 1, the upstream layer's output_valid.
REQ-006 The module SHALL have port input_ready, output, 1, which drives the upstream layer's output_ready.
REQ-007 The module SHALL have port input_data, input, T (signed), the upstream layer's output_data.
REQ-008 The module SHALL have port vec_valid, output, 1, meaning a complete M-word vector is held.
REQ-009 The module SHALL have port vec_ack, input, 1, meaning the consumer releases the held vector.
REQ-010 The module SHALL have port rd_addr, input, $clog2(M), the read index.
REQ-011 The module SHALL have port rd_data, output, T (signed), the registered read data.
REQ-012 With FC_CAPTURE_ARGMAX_EN defined, the module SHALL add outputs argmax_idx, $clog2(M), and argmax_val, T (signed).

Function
REQ-013 The module SHALL implement two states, FILL and HOLD; wr_idx SHALL count 0..M-1.
REQ-014 In FILL, input_ready SHALL be 1; in HOLD, input_ready SHALL be 0, with no combinational path from input_valid.
REQ-015 A transfer SHALL occur when input_valid && input_ready at a rising edge; the word SHALL be stored at buf[wr_idx], and wr_idx SHALL increment.
REQ-016 A transfer with wr_idx==M-1 SHALL set wr_idx to 0 and move to HOLD, so vec_valid=1 in the following cycle.
REQ-017 vec_valid SHALL be 1 exactly in HOLD.
REQ-018 In HOLD, vec_ack=1 SHALL return the block to FILL next cycle; input_ready SHALL rise in that cycle and the buffer contents SHALL be retained until overwritten.
REQ-019 vec_ack in FILL SHALL be ignored; input_valid in HOLD SHALL be ignored (no storage, no count change).
REQ-020 rd_data SHALL equal buf[rd_addr] one cycle after rd_addr is presented, in any state; rd_addr>=M SHALL yield 0.
REQ-021 Reads during FILL SHALL return the stale or new value per location, with no protection.
REQ-022 No data SHALL be lost under back-to-back transfers: M consecutive valid cycles SHALL fill the vector in M cycles.

Reset
REQ-023 When reset==0 at a rising edge: state=FILL, wr_idx=0, vec_valid=0, input_ready=1 from the next cycle, rd_data=0.
REQ-024 Argmax registers SHALL reset to idx=0 and val=most-negative T-bit value.
REQ-025 Reset mid-vector SHALL discard the partial count; buffer contents SHALL not need clearing.
REQ-026 Reset SHALL take priority over any simultaneous transfer or vec_ack.

Configuration
REQ-027 Macro FC_CAPTURE_ARGMAX_EN defined: argmax SHALL be tracked during FILL with a signed compare, strictly-greater replacement (ties keep the lowest index) and word 0 always loaded; argmax_idx and argmax_val SHALL be stable and valid while vec_valid=1.
REQ-028 Macro FC_CAPTURE_ARGMAX_EN undefined: no argmax ports or logic SHALL exist; all other behaviour SHALL be identical.

Structure
REQ-029 A shared package fc_capture_pkg SHALL hold the state enum (FILL, HOLD) and the argmax reset constant.
REQ-030 Storage SHALL be a sub-module capture_regfile (1 write port, 1 registered read port, M x T).

Verification
REQ-031 The bench SHALL apply reset, then stream 10 words -87,53,...,-12 back-to-back and check: vec_valid rises exactly 1 cycle after the 10th transfer, and input_ready=0.
REQ-032 In HOLD, the bench SHALL read addr 0..9 and check rd_data matches the sent words with 1-cycle latency; addr 12 SHALL return 0.
REQ-033 The bench SHALL assert input_valid in HOLD with word 99 and check: no change to buf or count; after vec_ack, the next vector is stored from index 0.
REQ-034 The bench SHALL send 4 words, assert reset, then send 10 new words and check: vec_valid only after 10 post-reset transfers, and data is correct.
REQ-035 With FC_CAPTURE_ARGMAX_EN, the bench SHALL send {5,-3,9,9,2,0,0,0,0,0} and check argmax_idx=2, argmax_val=9; an all-negative vector SHALL report the largest value.
REQ-036 The bench SHALL apply random input_valid gaps plus vec_ack pulses in FILL and check that vector integrity holds and vec_ack has no effect.
